fifo_1r1w_small_unhardened: RTL and testbench
=============================================

Name: fifo_1r1w_small_unhardened

Overview:
- Small, flop/latch-array based one-read-one-write FIFO built from generic logic, with no hard RAM macros.
- Used as elastic buffering between a manycore endpoint and host-side DPI consumers, for example request and response queues toward the host.
- Input side uses a ready/valid handshake; output side uses valid/yumi.
- Data written is visible at the output one cycle later; there is no bypass path.

Parameters:
- els_p, default 4: number of entries. Must be ≥2; any integer is legal (need not be a power of 2).
- width_p, default 32: data width in bits, ≥1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, active-low and synchronous; sampled on the rising edge of clk_i.
- v_i  in  1  producer has valid data on data_i.
- ready_o  out  1  FIFO can accept an entry this cycle (not full).
- data_i  in  width_p  write data.
- v_o  out  1  FIFO holds at least one entry (not empty).
- data_o  out  width_p  head-of-queue data, valid when v_o=1.
- yumi_i  in  1  consumer takes the head entry this cycle; legal only when v_o=1.

Behaviour:
- State:
  - write pointer wptr and read pointer rptr, each 0..els_p-1;
  - storage array mem[els_p][width_p];
  - one extra bit (or an occupancy counter 0..els_p) to distinguish full from empty when wptr==rptr.
- Reset (reset_n_i=0 at a rising edge): wptr=rptr=0, FIFO empty.
  - The cycle after reset: v_o=0, ready_o=1.
  - mem contents are not reset.
  - Reset overrides any same-cycle enqueue or dequeue.
- Enqueue fires when v_i & ready_o:
  - mem[wptr] <= data_i;
  - wptr advances by 1, wrapping from els_p-1 to 0.
  - v_i while ready_o=0 is ignored: no write, no pointer change, and the producer must hold data.
- Dequeue fires when yumi_i (requires v_o=1): rptr advances by 1, wrapping from els_p-1 to 0.
  - yumi_i while v_o=0 is a protocol error. The RTL ignores it (no pointer change) and a simulation-only assertion flags it.
- Outputs are combinational from registered state:
  - ready_o = ~full, v_o = ~empty;
  - data_o = mem[rptr], an asynchronous read of the registered array.
  - ready_o does not depend on yumi_i; v_o does not depend on v_i.
- Latency: an entry enqueued at edge N is visible on v_o/data_o after edge N (next cycle). No same-cycle pass-through when empty.
- Simultaneous enqueue and dequeue:
  - Occupancy is unchanged and both pointers advance.
  - Neither full nor empty changes, except the empty→empty case, which cannot occur since dequeue requires v_o=1.
  - When full, an enqueue cannot fire (ready_o=0) even if yumi_i=1 in the same cycle; ready_o rises the cycle after the dequeue.
  - When holding one entry with enqueue+dequeue: the head is consumed, the new entry is written, and v_o stays 1 with data_o = new entry.
- Ordering: strict FIFO. No entry is lost, duplicated or reordered across pointer wrap-around, for any els_p including non-powers of 2.
- Full: occupancy == els_p. Empty: occupancy == 0.
- Reset mid-operation discards all entries; data_o is don't-care while v_o=0.
- Implementation: synthesizable except the assertion; single clock domain; no X propagation to v_o/ready_o after reset.

Test Plan:
- Reset then idle: hold reset_n_i=0 two cycles, release → v_o=0 and ready_o=1 on the first cycle after release; remains so with no stimulus.
- Fill/drain (els_p=4, width_p=32): enqueue 0xA0..0xA3 on consecutive cycles with yumi_i=0 → ready_o=0 after the 4th; a 5th v_i is ignored. Then yumi each cycle → data_o 0xA0,0xA1,0xA2,0xA3 in order, v_o=0 afterward, ready_o=1 after the first dequeue.
- Latency: enqueue 0x55 into an empty FIFO at edge N → v_o=0 before edge N, v_o=1 with data_o=0x55 in the cycle after.
- Simultaneous ops:
  - With 1 entry (0x11), assert v_i(0x22) and yumi_i together → next cycle v_o=1, data_o=0x22.
  - When full, v_i+yumi_i → no enqueue, occupancy drops to 3, ready_o=1 next cycle.
- Wrap-around with els_p=3: stream 100 random words with random v_i/yumi_i → output sequence equals input sequence exactly; occupancy never exceeds 3.
- Reset mid-stream: with 2 entries held, pulse reset_n_i low one cycle → next cycle v_o=0, ready_o=1; a subsequent enqueue of 0x77 emerges as the first output.

Source files
------------

// File: rtl/fifo_1r1w_small_unhardened.sv
// Small one-read/one-write FIFO built from a flop array, ready/valid in and valid/yumi out.
// Written data appears at the head one cycle later; there is no bypass path.
module fifo_1r1w_small_unhardened #(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CntW = $clog2(els_p + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(els_p - 1);
  localparam cnt_t FullCnt = cnt_t'(els_p);

  logic [width_p-1:0] mem_q [els_p];
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;
  logic enq, deq;

  assign ready_o = (count_q != FullCnt);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];

  assign enq = v_i & ready_o;
  // An illegal yumi on an empty queue is dropped here rather than corrupting pointers.
  assign deq = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : ptr_t'(wptr_q + ptr_t'(1));
    end
    if (deq) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : ptr_t'(rptr_q + ptr_t'(1));
    end
    case ({enq, deq})
      2'b10:   count_d = cnt_t'(count_q + cnt_t'(1));
      2'b01:   count_d = cnt_t'(count_q - cnt_t'(1));
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  yumiWhenEmpty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted while FIFO empty");

endmodule

// File: tb/tb_fifo_1r1w_small_unhardened.sv
// Directed bench for the small FIFO: a 4-deep/32-bit instance for the directed scenarios
// and a 3-deep instance for a randomized wrap-around stream against a queue model.
module tb_fifo_1r1w_small_unhardened;

  logic        clk = 1'b0;
  logic        resetN;
  logic        vIn, yumiIn;
  logic [31:0] dataIn;
  logic        readyOut, vOut;
  logic [31:0] dataOut;

  logic        vIn3, yumiIn3;
  logic [31:0] dataIn3;
  logic        readyOut3, vOut3;
  logic [31:0] dataOut3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_1r1w_small_unhardened #(.els_p(4), .width_p(32)) dut (
    .clk_i(clk), .reset_n_i(resetN), .v_i(vIn), .ready_o(readyOut),
    .data_i(dataIn), .v_o(vOut), .data_o(dataOut), .yumi_i(yumiIn)
  );

  fifo_1r1w_small_unhardened #(.els_p(3), .width_p(32)) dut3 (
    .clk_i(clk), .reset_n_i(resetN), .v_i(vIn3), .ready_o(readyOut3),
    .data_i(dataIn3), .v_o(vOut3), .data_o(dataOut3), .yumi_i(yumiIn3)
  );

  // Advance one edge and settle, so outputs are sampled away from the clock edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic y);
    vIn    = v;
    dataIn = d;
    yumiIn = y;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    cycle();
    cycle();
    resetN = 1'b1;
    #1;
    total++;
    if (vOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release v_o=%b ready_o=%b expected v_o=0 ready_o=1", vOut, readyOut);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (vOut !== 1'b0 || readyOut !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_idle%0d v_o=%b ready_o=%b expected v_o=0 ready_o=1", i, vOut, readyOut);
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (readyOut !== 1'b1) begin
        bad++;
        $display("[TB] FAIL fill_ready%0d ready_o=%b expected 1", i, readyOut);
      end
      applyStimulus(1'b1, 32'hA0 + i, 1'b0);
      cycle();
    end
    total++;
    if (readyOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_ready ready_o=%b expected 0", readyOut);
    end
    applyStimulus(1'b1, 32'hEE, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (readyOut !== 1'b0 || vOut !== 1'b1 || dataOut !== 32'hA0) begin
      bad++;
      $display("[TB] FAIL fifth_ignored ready_o=%b v_o=%b data_o=%h expected 0 1 a0", readyOut, vOut, dataOut);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (vOut !== 1'b1 || dataOut !== 32'hA0 + i) begin
        bad++;
        $display("[TB] FAIL drain%0d v_o=%b data_o=%h expected 1 %h", i, vOut, dataOut, 32'hA0 + i);
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      cycle();
      if (i == 0) begin
        total++;
        if (readyOut !== 1'b1) begin
          bad++;
          $display("[TB] FAIL ready_after_deq ready_o=%b expected 1", readyOut);
        end
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drained v_o=%b ready_o=%b expected 0 1", vOut, readyOut);
    end
  endtask

  task automatic test_latency();
    applyStimulus(1'b1, 32'h55, 1'b0);
    #1;
    total++;
    if (vOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_before v_o=%b expected 0", vOut);
    end
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b1 || dataOut !== 32'h55) begin
      bad++;
      $display("[TB] FAIL latency_after v_o=%b data_o=%h expected 1 55", vOut, dataOut);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 32'h11, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h22, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b1 || dataOut !== 32'h22) begin
      bad++;
      $display("[TB] FAIL one_entry_swap v_o=%b data_o=%h expected 1 22", vOut, dataOut);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL swap_drained v_o=%b expected 0", vOut);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hB0 + i, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 32'hCC, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (readyOut !== 1'b1 || dataOut !== 32'hB1) begin
      bad++;
      $display("[TB] FAIL full_enq_deq ready_o=%b data_o=%h expected 1 b1", readyOut, dataOut);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (vOut !== 1'b1 || dataOut !== 32'hB0 + i) begin
        bad++;
        $display("[TB] FAIL full_drain%0d v_o=%b data_o=%h expected 1 %h", i, vOut, dataOut, 32'hB0 + i);
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      cycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_drained v_o=%b expected 0 (occupancy should be 3)", vOut);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, 32'h01, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h02, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    resetN = 1'b0;
    cycle();
    resetN = 1'b1;
    total++;
    if (vOut !== 1'b0 || readyOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset v_o=%b ready_o=%b expected 0 1", vOut, readyOut);
    end
    applyStimulus(1'b1, 32'h77, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    total++;
    if (vOut !== 1'b1 || dataOut !== 32'h77) begin
      bad++;
      $display("[TB] FAIL post_reset_first v_o=%b data_o=%h expected 1 77", vOut, dataOut);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  // Random stream through the 3-deep instance exercises non-power-of-two pointer wrap.
  task automatic test_wraparound();
    logic [31:0] model[$];
    int sent = 0;
    int recvd = 0;
    int budget = 2000;
    logic v, y;
    while (recvd < 100 && budget > 0) begin
      budget--;
      total++;
      if (model.size() > 3 || readyOut3 !== (model.size() < 3) || vOut3 !== (model.size() > 0)) begin
        bad++;
        $display("[TB] FAIL wrap_flags occ=%0d ready_o=%b v_o=%b", model.size(), readyOut3, vOut3);
      end
      v = (sent < 100) && ($urandom_range(0, 3) != 0);
      y = (model.size() > 0) && ($urandom_range(0, 2) != 0);
      vIn3    = v;
      dataIn3 = $urandom;
      yumiIn3 = y;
      if (y) begin
        total++;
        if (dataOut3 !== model[0]) begin
          bad++;
          $display("[TB] FAIL wrap_data%0d data_o=%h expected %h", recvd, dataOut3, model[0]);
        end
        void'(model.pop_front());
        recvd++;
      end
      if (v && readyOut3 === 1'b1) begin
        model.push_back(dataIn3);
        sent++;
      end
      cycle();
    end
    vIn3 = 1'b0;
    yumiIn3 = 1'b0;
    total++;
    if (recvd != 100) begin
      bad++;
      $display("[TB] FAIL wrap_timeout received=%0d expected 100", recvd);
    end
  endtask

  initial begin
    resetN  = 1'b0;
    vIn3    = 1'b0;
    yumiIn3 = 1'b0;
    dataIn3 = '0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_reset_midstream();
    test_wraparound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
